// File: rtl/atari_write_capture.sv
// Atari 7800 cartridge-bus write capture: PHI2-qualified write commit, POKEY write queue,
// optional $2200 control register (enabled by defining ATARI_WCAP_2200_EN).
module atari_write_capture #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [15:0]                   a_sync,
    input  logic [7:0]                    d_in,
    input  logic                          phi2_sync,
    input  logic                          rw_sync,
    input  logic                          halt_sync,
    input  logic                          pokey_ready,
    output logic                          pokey_we,
    output logic [3:0]                    pokey_addr,
    output logic [7:0]                    pokey_data,
    output logic [7:0]                    ctrl_2200,
    output logic                          ctrl_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HIGH, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             shadow_valid_q, shadow_valid_d;
    logic             shadow_ctrl_q, shadow_ctrl_d;
    logic [3:0]       shadow_addr_q, shadow_addr_d;
    logic [7:0]       shadow_data_q, shadow_data_d;

    logic [11:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             we_q, we_d;
    logic [11:0]      word_q, word_d;

    logic pokey_hit, ctrl_hit, qualify;
    logic commit_push, commit_ctrl, pop, full, push_ok;

    assign pokey_hit = (a_sync[15:4] == 12'h045);
`ifdef ATARI_WCAP_2200_EN
    assign ctrl_hit  = (a_sync == 16'h2200);
`else
    assign ctrl_hit  = 1'b0;
`endif
    assign qualify = phi2_sync && !rw_sync && halt_sync && (pokey_hit || ctrl_hit);
    assign cnt_inc = (cnt_q == SETTLE_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state; the exit sample's increment counts the final high sample
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (phi2_sync) state_d = HIGH;
            HIGH:    if (!phi2_sync)
                         state_d = (shadow_valid_q && cnt_inc == SETTLE_MAX) ? COMMIT : IDLE;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        commit_push = (state_q == COMMIT) && !shadow_ctrl_q;
        commit_ctrl = (state_q == COMMIT) &&  shadow_ctrl_q;
    end

    // High-time counter and bus shadow; last qualifying sample wins
    always_comb begin
        cnt_d          = cnt_q;
        shadow_valid_d = shadow_valid_q;
        shadow_ctrl_d  = shadow_ctrl_q;
        shadow_addr_d  = shadow_addr_q;
        shadow_data_d  = shadow_data_q;
        case (state_q)
            IDLE: if (phi2_sync) begin
                cnt_d          = '0;
                shadow_valid_d = 1'b0;
            end
            HIGH: begin
                cnt_d = cnt_inc;
                if (qualify) begin
                    shadow_valid_d = 1'b1;
                    shadow_ctrl_d  = ctrl_hit;
                    shadow_addr_d  = a_sync[3:0];
                    shadow_data_d  = d_in;
                end
            end
            default: ;
        endcase
    end

    // Write queue; a pop in the same cycle frees room for a push into a full queue
    always_comb begin
        pop        = (level_q != '0) && pokey_ready;
        full       = (level_q == LVL_FULL);
        push_ok    = commit_push && (!full || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d    = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        overflow_d = overflow_q || (commit_push && !push_ok);
        we_d       = pop;
        word_d     = pop ? fifo_mem[rd_ptr_q] : word_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= {shadow_addr_q, shadow_data_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            shadow_valid_q <= 1'b0;
            shadow_ctrl_q  <= 1'b0;
            shadow_addr_q  <= '0;
            shadow_data_q  <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            overflow_q     <= 1'b0;
            we_q           <= 1'b0;
            word_q         <= '0;
        end else begin
            cnt_q          <= cnt_d;
            shadow_valid_q <= shadow_valid_d;
            shadow_ctrl_q  <= shadow_ctrl_d;
            shadow_addr_q  <= shadow_addr_d;
            shadow_data_q  <= shadow_data_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            overflow_q     <= overflow_d;
            we_q           <= we_d;
            word_q         <= word_d;
        end
    end

    assign pokey_we   = we_q;
    assign pokey_addr = word_q[11:8];
    assign pokey_data = word_q[7:0];
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

`ifdef ATARI_WCAP_2200_EN
    logic [7:0] ctrl_q, ctrl_d;
    logic       ctrl_strobe_q, ctrl_strobe_d;

    always_comb begin
        ctrl_d        = commit_ctrl ? shadow_data_q : ctrl_q;
        ctrl_strobe_d = commit_ctrl;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= 8'h00;
            ctrl_strobe_q <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            ctrl_strobe_q <= ctrl_strobe_d;
        end
    end

    assign ctrl_2200   = ctrl_q;
    assign ctrl_strobe = ctrl_strobe_q;
`else
    // Control target is never shadowed, so commit_ctrl stays low here
    assign ctrl_2200   = 8'h00;
    assign ctrl_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_atari_write_capture.sv
// Self-checking bench for atari_write_capture: directed bus cycles plus randomized cycles
// scored against a per-bus-cycle behavioural model (queue of expected POKEY writes).
module tb_atari_write_capture;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 4;
`ifdef ATARI_WCAP_2200_EN
    localparam bit CTRL_EN = 1'b1;
`else
    localparam bit CTRL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] a_sync;
    logic [7:0]  d_in;
    logic        phi2_sync, rw_sync, halt_sync, pokey_ready;
    logic        pokey_we;
    logic [3:0]  pokey_addr;
    logic [7:0]  pokey_data;
    logic [7:0]  ctrl_2200;
    logic        ctrl_strobe;
    logic [2:0]  fifo_level;
    logic        overflow;

    atari_write_capture #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .a_sync(a_sync), .d_in(d_in),
        .phi2_sync(phi2_sync), .rw_sync(rw_sync), .halt_sync(halt_sync),
        .pokey_ready(pokey_ready), .pokey_we(pokey_we), .pokey_addr(pokey_addr),
        .pokey_data(pokey_data), .ctrl_2200(ctrl_2200), .ctrl_strobe(ctrl_strobe),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0, strobe_cnt = 0;
    int since_fall = 0, we_lat = -1, ctrl_lat = -1;

    logic [11:0] exp_q[$];
    logic        exp_ovf  = 1'b0;
    logic [7:0]  exp_ctrl = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock; every strobe is scored against the head of the expected queue.
    task automatic step();
        @(posedge clk);
        #1;
        since_fall++;
        if (pokey_we) begin
            we_cnt++;
            we_lat = since_fall;
            if (exp_q.size() == 0) begin
                check("we_unexpected", 32'(pokey_we), 32'd0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("we_payload", {20'd0, pokey_addr, pokey_data}, {20'd0, e});
                $display("pokey write addr=%0h data=%02h", pokey_addr, pokey_data);
            end
        end
        if (ctrl_strobe) begin
            strobe_cnt++;
            ctrl_lat = since_fall;
        end
    endtask

    // One PHI2 period: hc high samples, then low; the model decides its outcome from the rules.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                             input logic halt, input int hc);
        a_sync = a; d_in = d; rw_sync = rw; halt_sync = halt; phi2_sync = 1'b1;
        repeat (hc) step();
        phi2_sync  = 1'b0;
        since_fall = -1;
        if (hc >= SETTLE && !rw && halt) begin
            if (a[15:4] == 12'h045) begin
                if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
                else exp_q.push_back({a[3:0], d});
            end else if (CTRL_EN && a == 16'h2200) begin
                exp_ctrl = d;
            end
        end
        repeat (4) step();
        rw_sync = 1'b1;
        $display("bus a=%04h d=%02h rw=%0b halt=%0b high=%0d level=%0d ovf=%0b ctrl=%02h",
                 a, d, rw, halt, hc, fifo_level, overflow, ctrl_2200);
        check("level", 32'(fifo_level), 32'(exp_q.size()));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("ctrl_2200", 32'(ctrl_2200), 32'(exp_ctrl));
    endtask

    initial begin
        int w0, s0;
        reset_n = 1'b0; a_sync = '0; d_in = '0; phi2_sync = 1'b0;
        rw_sync = 1'b1; halt_sync = 1'b1; pokey_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(pokey_we), 0);
        check("rst_addr", 32'(pokey_addr), 0);
        check("rst_data", 32'(pokey_data), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_ctrl", 32'(ctrl_2200), 0);
        check("rst_strobe", 32'(ctrl_strobe), 0);
        reset_n = 1'b1;
        repeat (2) step();

        // Single write, strobe two edges after the first low sample
        pokey_ready = 1'b1;
        bus_cycle(16'h0451, 8'hA5, 1'b0, 1'b1, 8);
        check("single_lat", 32'(we_lat), 32'd2);
        check("single_cnt", 32'(we_cnt), 32'd1);

        // Glitch filter
        w0 = we_cnt;
        bus_cycle(16'h0452, 8'h77, 1'b0, 1'b1, 2);
        bus_cycle(16'h0452, 8'h78, 1'b0, 1'b1, 3);
        check("glitch_drop", 32'(we_cnt), 32'(w0));
        bus_cycle(16'h0452, 8'h79, 1'b0, 1'b1, 4);
        check("settle_ok", 32'(we_cnt), 32'(w0 + 1));

        // Address / direction / HALT filtering
        w0 = we_cnt; s0 = strobe_cnt;
        bus_cycle(16'h0460, 8'h11, 1'b0, 1'b1, 6);
        bus_cycle(16'h0451, 8'h22, 1'b1, 1'b1, 6);
        bus_cycle(16'h0455, 8'h33, 1'b0, 1'b0, 6);
        check("filter_we", 32'(we_cnt), 32'(w0));
        check("filter_strobe", 32'(strobe_cnt), 32'(s0));

        // Control register
        s0 = strobe_cnt;
        bus_cycle(16'h2200, 8'h3C, 1'b0, 1'b1, 6);
        check("ctrl_strobes", 32'(strobe_cnt), 32'(s0 + (CTRL_EN ? 1 : 0)));
`ifdef ATARI_WCAP_2200_EN
        check("ctrl_lat", 32'(ctrl_lat), 32'd1);
`endif

        // Backpressure and overflow
        pokey_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            bus_cycle(16'h0450 + 16'(i), 8'h10 + 8'(i), 1'b0, 1'b1, 5);
        check("bp_level", 32'(fifo_level), 32'd4);
        check("bp_ovf", 32'(overflow), 32'd1);
        w0 = we_cnt;
        pokey_ready = 1'b1;
        repeat (6) step();
        check("drain_cnt", 32'(we_cnt), 32'(w0 + 4));
        check("drain_level", 32'(fifo_level), 32'd0);

        // Reset with entries queued
        pokey_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            bus_cycle(16'h045A + 16'(i), 8'hC0 + 8'(i), 1'b0, 1'b1, 5);
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_level", 32'(fifo_level), 0);
        check("async_we", 32'(pokey_we), 0);
        check("async_addr", 32'(pokey_addr), 0);
        check("async_data", 32'(pokey_data), 0);
        check("async_ovf", 32'(overflow), 0);
        check("async_ctrl", 32'(ctrl_2200), 0);
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_ctrl = 8'h00;
        #12;
        reset_n = 1'b1;
        w0 = we_cnt;
        pokey_ready = 1'b1;
        repeat (10) step();
        check("post_rst_quiet", 32'(we_cnt), 32'(w0));
        bus_cycle(16'h0457, 8'h5A, 1'b0, 1'b1, 4);
        check("post_rst_write", 32'(we_cnt), 32'(w0 + 1));

        // Randomized bus cycles
        for (int r = 0; r < 40; r++) begin
            logic [15:0] a;
            int sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0, 1, 2: a = {12'h045, 4'($urandom_range(0, 15))};
                3:       a = 16'h2200;
                4:       a = 16'($urandom);
                default: a = {12'h046, 4'($urandom_range(0, 15))};
            endcase
            pokey_ready = ($urandom_range(0, 2) != 0);
            bus_cycle(a, 8'($urandom), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 7) != 0), int'($urandom_range(1, 8)));
        end
        pokey_ready = 1'b1;
        repeat (8) step();
        check("final_level", 32'(fifo_level), 32'(exp_q.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/atari_write_capture.md
# atari_write_capture

Captures Atari 7800 CPU write cycles from the cartridge bus and delivers each one exactly once to the on-cartridge peripherals. Sits between the input-synchronisation registers and the POKEY core: qualifies writes by PHI2 high time, commits them on the PHI2 falling edge, and queues POKEY register writes in a small FIFO. The POKEY core consumes them at its own pace; writes to the $2200 menu-control register are decoded into a holding register.

## Interface
- FIFO_DEPTH, 4, POKEY write queue entries; power of two, 2..16
- SETTLE_CYCLES, 4, minimum consecutive PHI2-high samples for a write to be valid (glitch filter)
- clk  in  1  system clock, 27 MHz
- reset_n  in  1  asynchronous, active-low reset
- a_sync  in  16  synchronised address bus
- d_in  in  8  data bus as seen through the buffer (write direction)
- phi2_sync  in  1  synchronised PHI2
- rw_sync  in  1  synchronised R/W (0 = write)
- halt_sync  in  1  synchronised HALT (0 = MARIA DMA, ignore bus)
- pokey_ready  in  1  POKEY core can accept a register write this cycle
- pokey_we  out  1  one-cycle write strobe to POKEY
- pokey_addr  out  4  POKEY register index, valid with pokey_we
- pokey_data  out  8  POKEY write data, valid with pokey_we
- ctrl_2200  out  8  last value written to $2200
- ctrl_strobe  out  1  one-cycle pulse when ctrl_2200 is updated
- fifo_level  out  clog2(FIFO_DEPTH)+1  current queue occupancy
- overflow  out  1  sticky: a POKEY write was dropped because the queue was full

## Operation
- Decode: POKEY target = a_sync[15:4] == 12'h045; control target = a_sync == 16'h2200.
- FSM states: IDLE, HIGH, COMMIT.
- IDLE: on phi2_sync == 1, clear the high counter, clear the shadow-valid flag, and go to HIGH.
- HIGH: each cycle, increment the high counter, saturating at SETTLE_CYCLES. While phi2_sync, !rw_sync, halt_sync and a target is decoded, reload the shadow address/data/target from the bus and set shadow-valid. The last qualifying sample wins.
- Leaving HIGH: on the first phi2_sync == 0 sample, go to COMMIT if shadow-valid and the counter has reached SETTLE_CYCLES. Otherwise go to IDLE and discard the shadow (short pulse or read cycle).
- COMMIT (one cycle):
  - POKEY target: push {addr[3:0], data} into the FIFO.
  - Control target: load ctrl_2200 and pulse ctrl_strobe.
  - Then go to IDLE.
- Drain: when the FIFO is non-empty and pokey_ready == 1, pop one entry, drive pokey_addr/pokey_data, and pulse pokey_we for that cycle.
- Full FIFO: a push is dropped and overflow is set; queue contents are unchanged.
- Simultaneous push and pop when full: both happen, the push is accepted, and the level is unchanged.
- Simultaneous push and pop when empty: the push is stored; nothing pops that cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The level counter is one bit wider.
- overflow clears only on reset.

## Timing
- Reset values: FSM = IDLE, FIFO empty, fifo_level = 0, pokey_we = 0, pokey_addr = 0, pokey_data = 0, ctrl_2200 = 8'h00, ctrl_strobe = 0, overflow = 0.
- Reset asserted mid-cycle or mid-queue discards everything; no partial write is emitted after release.
- Latency:
  - Edge N: first phi2_sync low sample; the FSM enters COMMIT at edge N.
  - Edge N+1: push lands and fifo_level increments; ctrl_2200 and ctrl_strobe update here.
  - Edge N+2: earliest pokey_we, if pokey_ready.
- pokey_addr and pokey_data are registered and hold their last value between strobes.
- At most one commit per PHI2 period. A sustained pop rate of one per clock is supported.

## Configuration
- ATARI_WCAP_2200_EN defined: $2200 decode, ctrl_2200 and ctrl_strobe function as above.
- ATARI_WCAP_2200_EN undefined: $2200 is not decoded, so those writes never set shadow-valid. ctrl_2200 is tied to 8'h00 and ctrl_strobe to 0; POKEY behaviour is identical.

## Test plan
- Single write: PHI2 high for 8 cycles with a = $0451, d = $A5, rw = 0, then PHI2 falls, pokey_ready = 1 -> exactly one pokey_we two cycles after the fall, with pokey_addr = 1 and pokey_data = $A5.
- Glitch filter: PHI2 high for 2 cycles with a = $0452, rw = 0 -> no pokey_we and fifo_level stays 0. The same cycle with 4 high cycles -> one write.
- Backpressure and overflow: pokey_ready = 0, five writes to $0450..$0454 with data $10..$14 -> fifo_level = 4, overflow = 1. Then pokey_ready = 1 -> four strobes, data $10..$13 in order.
- Filtering: a write to $0460, a read from $0451, and a write to $0455 with halt_sync = 0 -> no pokey_we, no ctrl_strobe.
- Control register: a write of $3C to $2200 -> ctrl_2200 = $3C with a one-cycle ctrl_strobe at N+1, and the FIFO is untouched. With the macro undefined, ctrl_2200 stays $00.
- Reset mid-operation: three entries queued, reset_n pulsed low -> all outputs at reset values immediately. No pokey_we after release until a new valid write occurs.
